digit_entry: RTL

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/memgame_pkg.sv | 33 +++
 rtl/entry_timer.sv | 41 ++++
 rtl/digit_entry.sv | 130 +++++++++++++
 3 files changed

// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory-game digit entry block.
package memgame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam int         NUM_DIGITS = 4;

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        logic [3:0] r;
        if (d >= DIGIT_MAX) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        logic [3:0] r;
        if (d == 4'd0) begin
            r = DIGIT_MAX;
        end else begin
            r = d - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Idle counter for digit_entry: fires on the TIMEOUT_CYCLES-th consecutive idle ENTRY cycle.
module entry_timer
#(
    parameter int TIMEOUT_CYCLES = 500_000_000
)
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count idle ENTRY cycles; any activity or leaving ENTRY restarts from zero
    always_comb begin
        count_d = count_q;
        if (!en_i || clear_i || (count_q == CNT_LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && !clear_i && (count_q == CNT_LAST);

endmodule

// File: rtl/digit_entry.sv
// Four-digit BCD entry with cursor, gated submit and a held result for the comparator.
// Optional idle-timeout forced submit enabled by macro DIGIT_ENTRY_TIMEOUT_EN.
module digit_entry
    import memgame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500_000_000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_next,
    input  logic        btn_back,
    input  logic        btn_submit,
    output logic [15:0] user_int,
    output logic [1:0]  cursor,
    output logic        active,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        timed_out
);

    localparam logic [1:0] LAST_CURSOR = 2'(NUM_DIGITS - 1);

    state_e      state_q;
    logic [15:0] digits_q;
    logic [1:0]  cursor_q;
    logic        active_q;
    logic        out_valid_q;
    logic        timed_out_q;
    logic [3:0]  cur_digit_s;
    logic        expired_s;

    assign cur_digit_s = digits_q[{cursor_q, 2'b00} +: 4];

`ifdef DIGIT_ENTRY_TIMEOUT_EN
    logic pulse_s;
    assign pulse_s = btn_inc | btn_dec | btn_next | btn_back | btn_submit | start;

    entry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_entry_timer (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == ST_ENTRY),
        .clear_i   (pulse_s),
        .expired_o (expired_s)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expired_s          = 1'b0;
`endif

    // Round control: state, digits, cursor and all status flags move together
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            digits_q    <= 16'h0000;
            cursor_q    <= 2'd0;
            active_q    <= 1'b0;
            out_valid_q <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        digits_q <= 16'h0000;
                        cursor_q <= 2'd0;
                        state_q  <= ST_ENTRY;
                        active_q <= 1'b1;
                    end
                end
                ST_ENTRY: begin
                    // The highest-priority pulse consumes the cycle even when it has no effect
                    if (start) begin
                        digits_q <= 16'h0000;
                        cursor_q <= 2'd0;
                    end else if (btn_submit) begin
                        if (cursor_q == LAST_CURSOR) begin
                            state_q     <= ST_HOLD;
                            active_q    <= 1'b0;
                            out_valid_q <= 1'b1;
                            timed_out_q <= 1'b0;
                        end
                    end else if (btn_back) begin
                        if (cursor_q != 2'd0) begin
                            cursor_q <= cursor_q - 2'd1;
                        end
                    end else if (btn_next) begin
                        if (cursor_q != LAST_CURSOR) begin
                            cursor_q <= cursor_q + 2'd1;
                        end
                    end else if (btn_inc) begin
                        digits_q[{cursor_q, 2'b00} +: 4] <= digit_inc(cur_digit_s);
                    end else if (btn_dec) begin
                        digits_q[{cursor_q, 2'b00} +: 4] <= digit_dec(cur_digit_s);
                    end else if (expired_s) begin
                        state_q     <= ST_HOLD;
                        active_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        timed_out_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        timed_out_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    active_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                    timed_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign user_int  = digits_q;
    assign cursor    = cursor_q;
    assign active    = active_q;
    assign out_valid = out_valid_q;
    assign timed_out = timed_out_q;

endmodule
